// File: rtl/count_tracker.sv
// Passive monitor for an up/down counter output: infers and locks the counting
// direction, and flags wraps, loads (jumps), holds and reversals.
module count_tracker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned EVT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             dir,
    output logic             locked,
    output logic             wrap,
    output logic             jump,
    output logic             rev,
    output logic             hold,
    output logic [EVT_W-1:0] evt_cnt,
    output logic [WIDTH-1:0] last_q
);

    localparam int unsigned RUN_W = 4;
    localparam logic [WIDTH-1:0] Q_MAX   = '1;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] LOCK_TH = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {S_EMPTY, S_ACQ, S_LOCKED} state_t;
    typedef enum logic [1:0] {C_UP, C_DN, C_SAME, C_JUMP} cls_t;

    state_t           state, nxt_state;
    cls_t             cls;
    logic             step_up;
    logic             cand_dir, nxt_cand;
    logic [RUN_W-1:0] run_cnt, nxt_run, run_inc;
    logic [EVT_W-1:0] evt_inc, nxt_evt;
    logic [WIDTH-1:0] nxt_last_q;
    logic             nxt_dir, nxt_locked, nxt_wrap, nxt_jump, nxt_rev, nxt_hold;

    // Classify the new sample against the previous one, modulo 2^WIDTH.
    always_comb begin
        cls = C_JUMP;
        if (q_in == WIDTH'(last_q + WIDTH'(1)))      cls = C_UP;
        else if (q_in == WIDTH'(last_q - WIDTH'(1))) cls = C_DN;
        else if (q_in == last_q)                     cls = C_SAME;
    end

    assign step_up = (cls == C_UP);
    assign run_inc = (run_cnt == RUN_MAX) ? run_cnt : RUN_W'(run_cnt + RUN_W'(1));
    assign evt_inc = (evt_cnt == EVT_MAX) ? evt_cnt : EVT_W'(evt_cnt + EVT_W'(1));

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        nxt_state  = state;
        nxt_last_q = last_q;
        nxt_cand   = cand_dir;
        nxt_run    = run_cnt;
        nxt_dir    = dir;
        nxt_locked = locked;
        nxt_evt    = evt_cnt;
        nxt_wrap   = 1'b0;
        nxt_jump   = 1'b0;
        nxt_rev    = 1'b0;
        nxt_hold   = 1'b0;

        if (en) begin
            nxt_last_q = q_in;
            unique case (state)
                S_EMPTY: begin
                    nxt_state = S_ACQ;
                    nxt_run   = '0;
                end
                S_ACQ: begin
                    unique case (cls)
                        C_UP, C_DN: begin
                            nxt_cand = step_up;
                            if (run_cnt == '0 || step_up == cand_dir) nxt_run = run_inc;
                            else                                      nxt_run = RUN_W'(1);
                            if (nxt_run >= LOCK_TH) begin
                                nxt_state  = S_LOCKED;
                                nxt_dir    = step_up;
                                nxt_locked = 1'b1;
                            end
                        end
                        C_SAME:  nxt_hold = 1'b1;
                        default: nxt_run  = '0;
                    endcase
                end
                S_LOCKED: begin
                    unique case (cls)
                        C_UP, C_DN: begin
                            if (step_up == dir) begin
                                // A matching unit step wraps only from the boundary value.
                                nxt_wrap = dir ? (last_q == Q_MAX) : (last_q == '0);
                            end else begin
                                nxt_rev    = 1'b1;
                                nxt_evt    = evt_inc;
                                nxt_locked = 1'b0;
                                nxt_state  = S_ACQ;
                                nxt_cand   = step_up;
                                nxt_run    = RUN_W'(1);
                            end
                        end
                        C_SAME: nxt_hold = 1'b1;
                        default: begin
                            nxt_jump = 1'b1;
                            nxt_evt  = evt_inc;
                        end
                    endcase
                end
                default: nxt_state = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_EMPTY;
            last_q   <= '0;
            cand_dir <= 1'b0;
            run_cnt  <= '0;
            dir      <= 1'b0;
            locked   <= 1'b0;
            evt_cnt  <= '0;
            wrap     <= 1'b0;
            jump     <= 1'b0;
            rev      <= 1'b0;
            hold     <= 1'b0;
        end else begin
            state    <= nxt_state;
            last_q   <= nxt_last_q;
            cand_dir <= nxt_cand;
            run_cnt  <= nxt_run;
            dir      <= nxt_dir;
            locked   <= nxt_locked;
            evt_cnt  <= nxt_evt;
            wrap     <= nxt_wrap;
            jump     <= nxt_jump;
            rev      <= nxt_rev;
            hold     <= nxt_hold;
        end
    end

endmodule
